// File: rtl/apb_mem_master_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_mem_master_arb_if
// Bundles the TX/RX requester handshakes and the memory-side APB pins used
// by the Ethernet DMA arbiter.
//   master : arbiter view (drives gnt/done/err/rdata and the APB command)
//   slave  : environment view (requesters plus the buffer memory)
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface apb_mem_master_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // TX requester
  logic          tx_req_i;
  logic          tx_we_i;
  logic [AW-1:0] tx_addr_i;
  logic [DW-1:0] tx_wdata_i;
  logic          tx_gnt_o;
  logic          tx_done_o;
  logic          tx_err_o;
  logic [DW-1:0] tx_rdata_o;
  // RX requester
  logic          rx_req_i;
  logic          rx_we_i;
  logic [AW-1:0] rx_addr_i;
  logic [DW-1:0] rx_wdata_i;
  logic          rx_gnt_o;
  logic          rx_done_o;
  logic          rx_err_o;
  logic [DW-1:0] rx_rdata_o;
  // APB towards the buffer memory
  logic [AW-1:0] m_paddr_o;
  logic [DW-1:0] m_pwdata_o;
  logic          m_psel_o;
  logic          m_penable_o;
  logic          m_pwrite_o;
  logic          m_pready_i;
  logic [DW-1:0] m_prdata_i;

  modport master (
    input  tx_req_i, tx_we_i, tx_addr_i, tx_wdata_i,
    output tx_gnt_o, tx_done_o, tx_err_o, tx_rdata_o,
    input  rx_req_i, rx_we_i, rx_addr_i, rx_wdata_i,
    output rx_gnt_o, rx_done_o, rx_err_o, rx_rdata_o,
    output m_paddr_o, m_pwdata_o, m_psel_o, m_penable_o, m_pwrite_o,
    input  m_pready_i, m_prdata_i
  );

  modport slave (
    output tx_req_i, tx_we_i, tx_addr_i, tx_wdata_i,
    input  tx_gnt_o, tx_done_o, tx_err_o, tx_rdata_o,
    output rx_req_i, rx_we_i, rx_addr_i, rx_wdata_i,
    input  rx_gnt_o, rx_done_o, rx_err_o, rx_rdata_o,
    input  m_paddr_o, m_pwdata_o, m_psel_o, m_penable_o, m_pwrite_o,
    output m_pready_i, m_prdata_i
  );
endinterface
`default_nettype wire

// File: rtl/apb_mem_master_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_mem_master_arb
// Round-robin arbiter between the TX and RX DMA requesters for the single
// APB master port to the external buffer memory. Runs the two-phase APB
// transfer (SETUP, ACCESS), honours pready wait states and aborts a transfer
// that sees no pready within TIMEOUT ACCESS cycles.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module apb_mem_master_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  wire logic            pclk_i,
  input  wire logic            prst_i,
  apb_mem_master_arb_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Counter value seen during the final permitted ACCESS cycle
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state;
  logic            last_rx;   // 1 when the most recent grant went to RX
  logic            cur_rx;    // owner of the transfer in flight
  logic [CW-1:0]   cnt;       // non-ready ACCESS cycles so far
  logic            pick_rx;
  logic            finish;

  // Arbitration: a lone request wins; on a tie the requester not served last wins
  always_comb begin
    pick_rx = 1'b0;
    if (bus.rx_req_i && (!bus.tx_req_i || !last_rx))
      pick_rx = 1'b1;
  end

  // ACCESS ends on pready or when the wait budget is used up
  always_comb begin
    finish = 1'b0;
    if (bus.m_pready_i || (cnt == CNT_LAST))
      finish = 1'b1;
  end

  // Transfer sequencer with registered handshake and APB outputs
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state           <= IDLE;
      last_rx         <= 1'b1;
      cur_rx          <= 1'b0;
      cnt             <= '0;
      bus.m_paddr_o   <= '0;
      bus.m_pwdata_o  <= '0;
      bus.m_pwrite_o  <= 1'b0;
      bus.m_psel_o    <= 1'b0;
      bus.m_penable_o <= 1'b0;
      bus.tx_gnt_o    <= 1'b0;
      bus.tx_done_o   <= 1'b0;
      bus.tx_err_o    <= 1'b0;
      bus.tx_rdata_o  <= '0;
      bus.rx_gnt_o    <= 1'b0;
      bus.rx_done_o   <= 1'b0;
      bus.rx_err_o    <= 1'b0;
      bus.rx_rdata_o  <= '0;
    end else begin
      // Handshake outputs are single-cycle pulses
      bus.tx_gnt_o  <= 1'b0;
      bus.rx_gnt_o  <= 1'b0;
      bus.tx_done_o <= 1'b0;
      bus.rx_done_o <= 1'b0;
      bus.tx_err_o  <= 1'b0;
      bus.rx_err_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.tx_req_i || bus.rx_req_i) begin
            cur_rx          <= pick_rx;
            last_rx         <= pick_rx;
            bus.m_paddr_o   <= pick_rx ? bus.rx_addr_i  : bus.tx_addr_i;
            bus.m_pwdata_o  <= pick_rx ? bus.rx_wdata_i : bus.tx_wdata_i;
            bus.m_pwrite_o  <= pick_rx ? bus.rx_we_i    : bus.tx_we_i;
            bus.m_psel_o    <= 1'b1;
            bus.m_penable_o <= 1'b0;
            bus.tx_gnt_o    <= !pick_rx;
            bus.rx_gnt_o    <= pick_rx;
            state           <= SETUP;
          end
        end

        SETUP: begin
          bus.m_penable_o <= 1'b1;
          state           <= ACCESS;
        end

        ACCESS: begin
          if (finish) begin
            bus.m_psel_o    <= 1'b0;
            bus.m_penable_o <= 1'b0;
            cnt             <= '0;
            state           <= IDLE;
            // A timed-out transfer returns zero read data and flags err
            if (cur_rx) begin
              bus.rx_done_o <= 1'b1;
              bus.rx_err_o  <= !bus.m_pready_i;
              if (!bus.m_pready_i)
                bus.rx_rdata_o <= '0;
              else if (!bus.m_pwrite_o)
                bus.rx_rdata_o <= bus.m_prdata_i;
            end else begin
              bus.tx_done_o <= 1'b1;
              bus.tx_err_o  <= !bus.m_pready_i;
              if (!bus.m_pready_i)
                bus.tx_rdata_o <= '0;
              else if (!bus.m_pwrite_o)
                bus.tx_rdata_o <= bus.m_prdata_i;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          bus.m_psel_o    <= 1'b0;
          bus.m_penable_o <= 1'b0;
          cnt             <= '0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_master_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apb_mem_master_arb
// Self-checking bench: directed scenarios plus a completion scoreboard and a
// simple APB memory responder with configurable wait states.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_apb_mem_master_arb;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  apb_mem_master_arb_if #(.AW(AW), .DW(DW)) bus ();

  apb_mem_master_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk_i (clk),
    .prst_i (rst),
    .bus    (bus)
  );

  typedef struct {
    bit            is_rx;
    bit            err;
    bit            chk_rdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            wait_states = 0;
  bit            stuck = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  int            acc = 0;

  // Memory responder: pready after wait_states extra ACCESS cycles
  always @(posedge clk) begin
    #1;
    if (bus.m_psel_o && bus.m_penable_o) acc++;
    else acc = 0;
    bus.m_pready_i = bus.m_psel_o && bus.m_penable_o && !stuck && (acc == wait_states + 1);
    bus.m_prdata_i = mem_rdata;
  end

  // Scoreboard: every done pulse is matched against the oldest expectation
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (bus.tx_gnt_o || bus.rx_gnt_o) begin
        n_checks++;
        if (bus.tx_gnt_o && bus.rx_gnt_o) begin
          n_fail++;
          $display("FAIL gnt_exclusive: tx_gnt=%b rx_gnt=%b, required one", bus.tx_gnt_o, bus.rx_gnt_o);
        end
      end
      if (bus.tx_done_o || bus.rx_done_o) begin
        n_checks++;
        if (bus.tx_done_o && bus.rx_done_o) begin
          n_fail++;
          $display("FAIL done_exclusive: both done pulses high");
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: tx_done=%b rx_done=%b with nothing outstanding",
                   bus.tx_done_o, bus.rx_done_o);
        end else begin
          e = sb.pop_front();
          if (bus.rx_done_o !== e.is_rx) begin
            n_fail++;
            $display("FAIL done_owner: rx_done=%b, required %b", bus.rx_done_o, e.is_rx);
          end
          n_checks++;
          if ((e.is_rx ? bus.rx_err_o : bus.tx_err_o) !== e.err) begin
            n_fail++;
            $display("FAIL done_err: got %b, required %b", e.is_rx ? bus.rx_err_o : bus.tx_err_o, e.err);
          end
          if (e.chk_rdata) begin
            n_checks++;
            if ((e.is_rx ? bus.rx_rdata_o : bus.tx_rdata_o) !== e.rdata) begin
              n_fail++;
              $display("FAIL done_rdata: got %h, required %h",
                       e.is_rx ? bus.rx_rdata_o : bus.tx_rdata_o, e.rdata);
            end
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_checks++;
    if (bus.m_psel_o !== 1'b0 || bus.m_penable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_psel: psel=%b penable=%b, required 0 0", bus.m_psel_o, bus.m_penable_o);
    end
    n_checks++;
    if (bus.m_paddr_o !== '0 || bus.m_pwdata_o !== '0 || bus.m_pwrite_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: paddr=%h pwdata=%h pwrite=%b, required 0", bus.m_paddr_o, bus.m_pwdata_o, bus.m_pwrite_o);
    end
    n_checks++;
    if ({bus.tx_gnt_o, bus.tx_done_o, bus.tx_err_o, bus.rx_gnt_o, bus.rx_done_o, bus.rx_err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_hs: handshake outputs not 0");
    end
    n_checks++;
    if (bus.tx_rdata_o !== '0 || bus.rx_rdata_o !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: tx=%h rx=%h, required 0", bus.tx_rdata_o, bus.rx_rdata_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_tx_write;
    bus.tx_we_i = 1'b1; bus.tx_addr_i = 32'h0000_0040; bus.tx_wdata_i = 32'hDEAD_BEEF;
    bus.tx_req_i = 1'b1;
    sb.push_back('{is_rx: 1'b0, err: 1'b0, chk_rdata: 1'b0, rdata: '0});
    tick;
    n_checks++;
    if (bus.tx_gnt_o !== 1'b1 || bus.m_psel_o !== 1'b1 || bus.m_penable_o !== 1'b0) begin
      n_fail++;
      $display("FAIL txw_setup: gnt=%b psel=%b penable=%b, required 1 1 0", bus.tx_gnt_o, bus.m_psel_o, bus.m_penable_o);
    end
    n_checks++;
    if (bus.m_paddr_o !== 32'h40 || bus.m_pwdata_o !== 32'hDEAD_BEEF || bus.m_pwrite_o !== 1'b1) begin
      n_fail++;
      $display("FAIL txw_cmd: paddr=%h pwdata=%h pwrite=%b, required 00000040 deadbeef 1",
               bus.m_paddr_o, bus.m_pwdata_o, bus.m_pwrite_o);
    end
    bus.tx_req_i = 1'b0;
    tick;
    n_checks++;
    if (bus.m_psel_o !== 1'b1 || bus.m_penable_o !== 1'b1 || bus.m_pwrite_o !== 1'b1 || bus.tx_gnt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL txw_access: psel=%b penable=%b pwrite=%b gnt=%b, required 1 1 1 0",
               bus.m_psel_o, bus.m_penable_o, bus.m_pwrite_o, bus.tx_gnt_o);
    end
    tick;
    n_checks++;
    if (bus.tx_done_o !== 1'b1 || bus.m_psel_o !== 1'b0) begin
      n_fail++;
      $display("FAIL txw_latency: done=%b psel=%b three cycles after req, required 1 0", bus.tx_done_o, bus.m_psel_o);
    end
  endtask

  task automatic test_rx_read_wait;
    int n;
    int acc_n;
    wait_states = 3;
    mem_rdata = 32'h1234_5678;
    bus.rx_we_i = 1'b0; bus.rx_addr_i = 32'h0000_0100; bus.rx_wdata_i = 32'h0BAD_0BAD;
    bus.rx_req_i = 1'b1;
    sb.push_back('{is_rx: 1'b1, err: 1'b0, chk_rdata: 1'b1, rdata: 32'h1234_5678});
    tick;
    n_checks++;
    if (bus.rx_gnt_o !== 1'b1 || bus.m_paddr_o !== 32'h100 || bus.m_pwrite_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rxr_setup: gnt=%b paddr=%h pwrite=%b, required 1 00000100 0", bus.rx_gnt_o, bus.m_paddr_o, bus.m_pwrite_o);
    end
    bus.rx_req_i = 1'b0;
    n = 0;
    acc_n = 0;
    do begin
      tick;
      n++;
      if (bus.m_penable_o) acc_n++;
    end while (!bus.rx_done_o && n < 40);
    n_checks++;
    if (acc_n != 4 || !bus.rx_done_o) begin
      n_fail++;
      $display("FAIL rxr_waits: access cycles=%0d done=%b, required 4 1", acc_n, bus.rx_done_o);
    end
    mem_rdata = 32'hFFFF_0000;
    tick;
    tick;
    n_checks++;
    if (bus.rx_rdata_o !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL rxr_hold: rdata=%h, required 12345678", bus.rx_rdata_o);
    end
    wait_states = 0;
  endtask

  task automatic test_round_robin;
    int n;
    bus.tx_we_i = 1'b1; bus.tx_addr_i = 32'h200; bus.tx_wdata_i = 32'h1111_1111;
    bus.rx_we_i = 1'b1; bus.rx_addr_i = 32'h300; bus.rx_wdata_i = 32'h2222_2222;
    bus.tx_req_i = 1'b1;
    bus.rx_req_i = 1'b1;
    sb.push_back('{is_rx: 1'b0, err: 1'b0, chk_rdata: 1'b0, rdata: '0});
    sb.push_back('{is_rx: 1'b1, err: 1'b0, chk_rdata: 1'b0, rdata: '0});
    tick;
    n_checks++;
    if (bus.tx_gnt_o !== 1'b1 || bus.rx_gnt_o !== 1'b0 || bus.m_paddr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL rr_first: tx_gnt=%b rx_gnt=%b paddr=%h, required 1 0 00000200", bus.tx_gnt_o, bus.rx_gnt_o, bus.m_paddr_o);
    end
    bus.tx_req_i = 1'b0;
    n = 0;
    while (!bus.tx_done_o && n < 40) begin tick; n++; end
    n_checks++;
    if (!bus.tx_done_o) begin
      n_fail++;
      $display("FAIL rr_tx_done: tx_done=%b after %0d cycles, required 1", bus.tx_done_o, n);
    end
    // TX asks again while RX is still held: the tie must now go to RX
    bus.tx_addr_i = 32'h240; bus.tx_wdata_i = 32'h3333_3333;
    bus.tx_req_i = 1'b1;
    sb.push_back('{is_rx: 1'b0, err: 1'b0, chk_rdata: 1'b0, rdata: '0});
    tick;
    n_checks++;
    if (bus.rx_gnt_o !== 1'b1 || bus.tx_gnt_o !== 1'b0 || bus.m_paddr_o !== 32'h300 || bus.m_pwdata_o !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL rr_second: rx_gnt=%b tx_gnt=%b paddr=%h pwdata=%h, required 1 0 00000300 22222222",
               bus.rx_gnt_o, bus.tx_gnt_o, bus.m_paddr_o, bus.m_pwdata_o);
    end
    bus.rx_req_i = 1'b0;
    n = 0;
    while (!bus.rx_done_o && n < 40) begin tick; n++; end
    tick;
    n_checks++;
    if (bus.tx_gnt_o !== 1'b1 || bus.m_paddr_o !== 32'h240) begin
      n_fail++;
      $display("FAIL rr_third: tx_gnt=%b paddr=%h, required 1 00000240", bus.tx_gnt_o, bus.m_paddr_o);
    end
    bus.tx_req_i = 1'b0;
    n = 0;
    while (!bus.tx_done_o && n < 40) begin tick; n++; end
  endtask

  task automatic test_timeout;
    int n;
    int acc_n;
    stuck = 1'b1;
    bus.rx_we_i = 1'b0; bus.rx_addr_i = 32'h400;
    bus.rx_req_i = 1'b1;
    sb.push_back('{is_rx: 1'b1, err: 1'b1, chk_rdata: 1'b1, rdata: '0});
    tick;
    bus.rx_req_i = 1'b0;
    n = 0;
    acc_n = 0;
    do begin
      tick;
      n++;
      if (bus.m_penable_o) acc_n++;
    end while (!bus.rx_done_o && n < 60);
    n_checks++;
    if (acc_n != TIMEOUT || bus.rx_err_o !== 1'b1 || bus.m_psel_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_abort: access cycles=%0d err=%b psel=%b, required %0d 1 0", acc_n, bus.rx_err_o, bus.m_psel_o, TIMEOUT);
    end
    stuck = 1'b0;
    mem_rdata = 32'hCAFE_0001;
    bus.tx_we_i = 1'b0; bus.tx_addr_i = 32'h500;
    bus.tx_req_i = 1'b1;
    sb.push_back('{is_rx: 1'b0, err: 1'b0, chk_rdata: 1'b1, rdata: 32'hCAFE_0001});
    tick;
    bus.tx_req_i = 1'b0;
    n = 0;
    while (!bus.tx_done_o && n < 40) begin tick; n++; end
    n_checks++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL to_recover: done after %0d cycles from SETUP, required 2", n);
    end
  endtask

  task automatic test_reset_midway;
    int n;
    wait_states = 5;
    bus.tx_we_i = 1'b1; bus.tx_addr_i = 32'h600; bus.tx_wdata_i = 32'h4444_4444;
    bus.tx_req_i = 1'b1;
    tick;
    bus.tx_req_i = 1'b0;
    tick;
    tick;
    n_checks++;
    if (bus.m_penable_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstm_access: penable=%b, required 1", bus.m_penable_o);
    end
    rst = 1'b1;
    tick;
    n_checks++;
    if (bus.m_psel_o !== 1'b0 || bus.m_penable_o !== 1'b0 || bus.m_paddr_o !== '0 ||
        bus.m_pwrite_o !== 1'b0 || bus.tx_done_o !== 1'b0 || bus.tx_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstm_clear: psel=%b penable=%b paddr=%h pwrite=%b done=%b err=%b, required all 0",
               bus.m_psel_o, bus.m_penable_o, bus.m_paddr_o, bus.m_pwrite_o, bus.tx_done_o, bus.tx_err_o);
    end
    rst = 1'b0;
    wait_states = 0;
    bus.tx_we_i = 1'b0; bus.tx_addr_i = 32'h700;
    bus.rx_we_i = 1'b1; bus.rx_addr_i = 32'h800; bus.rx_wdata_i = 32'h5555_5555;
    bus.tx_req_i = 1'b1;
    bus.rx_req_i = 1'b1;
    sb.push_back('{is_rx: 1'b0, err: 1'b0, chk_rdata: 1'b1, rdata: 32'hCAFE_0001});
    sb.push_back('{is_rx: 1'b1, err: 1'b0, chk_rdata: 1'b0, rdata: '0});
    tick;
    n_checks++;
    if (bus.tx_gnt_o !== 1'b1 || bus.rx_gnt_o !== 1'b0 || bus.m_paddr_o !== 32'h700) begin
      n_fail++;
      $display("FAIL rstm_tie: tx_gnt=%b rx_gnt=%b paddr=%h, required 1 0 00000700", bus.tx_gnt_o, bus.rx_gnt_o, bus.m_paddr_o);
    end
    bus.tx_req_i = 1'b0;
    n = 0;
    while (!bus.tx_done_o && n < 40) begin tick; n++; end
    tick;
    n_checks++;
    if (bus.rx_gnt_o !== 1'b1 || bus.m_paddr_o !== 32'h800) begin
      n_fail++;
      $display("FAIL rstm_rx: rx_gnt=%b paddr=%h, required 1 00000800", bus.rx_gnt_o, bus.m_paddr_o);
    end
    bus.rx_req_i = 1'b0;
    n = 0;
    while (!bus.rx_done_o && n < 40) begin tick; n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_req_i = 1'b0; bus.tx_we_i = 1'b0; bus.tx_addr_i = '0; bus.tx_wdata_i = '0;
    bus.rx_req_i = 1'b0; bus.rx_we_i = 1'b0; bus.rx_addr_i = '0; bus.rx_wdata_i = '0;
    test_reset;
    test_tx_write;
    test_rx_read_wait;
    test_round_robin;
    test_timeout;
    test_reset_midway;
    tick;
    tick;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d transfers never completed, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
